// File: rtl/weight_loader.sv
// Weight RAM read sequencer: streams a block of weights out of the RAM and
// steers each returned word to one neuron unit, or to all of them at once.
module weight_loader #(
   parameter int DATA_W           = 32,
   parameter int NUM_UNITS        = 4,
   parameter int WEIGHTS_PER_UNIT = 8,
   parameter int ADDR_W           = 10,
   parameter int RAM_LATENCY      = 1
) (
   input  logic                          CLOCK,
   input  logic                          RESET,
   input  logic                          start,
   input  logic                          bcast,
   input  logic [ADDR_W-1:0]             base_addr,
   output logic                          busy,
   output logic                          done,
   output logic                          ram_rd,
   output logic [ADDR_W-1:0]             ram_addr,
   input  logic [DATA_W-1:0]             ram_out,
   output logic [NUM_UNITS*DATA_W-1:0]   weight,
   output logic [NUM_UNITS-1:0]          write
);

   localparam int N_FULL = NUM_UNITS * WEIGHTS_PER_UNIT;
   localparam int CNT_W  = $clog2(N_FULL + 1);
   localparam int WPU_W  = $clog2(WEIGHTS_PER_UNIT + 1);
   localparam int UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FINISH
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    k_q;
   logic [WPU_W-1:0]    w_q;
   logic [UNIT_W-1:0]   u_q;
   logic [ADDR_W-1:0]   base_q;
   logic                bcast_q;
   logic [CNT_W-1:0]    last_k;
   logic                issue;
   logic                take;

   logic [RAM_LATENCY-1:0] pv_q;
   logic [UNIT_W-1:0]      pu_q [RAM_LATENCY];

   assign last_k = bcast_q ? CNT_W'(WEIGHTS_PER_UNIT - 1)
                           : CNT_W'(N_FULL - 1);
   assign take   = (state_q == IDLE) && start;

   always_comb begin
      state_d  = state_q;
      issue    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      ram_rd   = 1'b0;
      ram_addr = '0;
      unique case (state_q)
         IDLE: begin
            if (start)
               state_d = ISSUE;
         end
         ISSUE: begin
            issue    = 1'b1;
            busy     = 1'b1;
            ram_rd   = 1'b1;
            ram_addr = base_q + ADDR_W'(k_q);
            if (k_q == last_k)
               state_d = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            // pipeline empty means the last word is on the outputs now
            if (pv_q == '0)
               state_d = FINISH;
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q <= IDLE;
         k_q     <= '0;
         w_q     <= '0;
         u_q     <= '0;
         base_q  <= '0;
         bcast_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (take) begin
            base_q  <= base_addr;
            bcast_q <= bcast;
            k_q     <= '0;
            w_q     <= '0;
            u_q     <= '0;
         end else if (issue) begin
            k_q <= k_q + CNT_W'(1);
            if (w_q == WPU_W'(WEIGHTS_PER_UNIT - 1)) begin
               w_q <= '0;
               u_q <= u_q + UNIT_W'(1);
            end else begin
               w_q <= w_q + WPU_W'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         pv_q <= '0;
         for (int i = 0; i < RAM_LATENCY; i++)
            pu_q[i] <= '0;
      end else begin
         pv_q[0] <= issue;
         pu_q[0] <= u_q;
         for (int i = 1; i < RAM_LATENCY; i++) begin
            pv_q[i] <= pv_q[i-1];
            pu_q[i] <= pu_q[i-1];
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      weight <= '0;
      write  <= '0;
      if (!RESET && pv_q[RAM_LATENCY-1]) begin
         for (int u = 0; u < NUM_UNITS; u++) begin
            if (bcast_q || pu_q[RAM_LATENCY-1] == UNIT_W'(u)) begin
               weight[u*DATA_W +: DATA_W] <= ram_out;
               write[u]                   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: latency 1 and latency 3 instances
// driven in lockstep, expected traffic queued at stimulus time.
module tb_weight_loader;

   typedef struct packed {
      int           cyc;
      logic [3:0]   wr;
      logic [127:0] wt;
   } wexp_t;

   typedef struct packed {
      int         cyc;
      logic [9:0] addr;
   } rexp_t;

   logic          CLOCK = 1'b0;
   logic          RESET;
   logic          start;
   logic          bcast;
   logic [9:0]    base_addr;

   logic          busy_a, done_a, rd_a;
   logic [9:0]    addr_a;
   logic [31:0]   rdata_a;
   logic [127:0]  weight_a;
   logic [3:0]    write_a;

   logic          busy_b, done_b, rd_b;
   logic [9:0]    addr_b;
   logic [31:0]   rdata_b;
   logic [127:0]  weight_b;
   logic [3:0]    write_b;

   int  cyc    = 0;
   int  errors = 0;
   int  checks = 0;
   bit  mon_on = 0;
   int  ba_lo = 1, ba_hi = 0, bb_lo = 1, bb_hi = 0;

   rexp_t rqa[$];
   wexp_t wqa[$];
   wexp_t wqb[$];
   int    dqa[$];
   int    dqb[$];

   logic [9:0] apa = '0;
   logic [9:0] apb0 = '0, apb1 = '0, apb2 = '0;

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) cyc <= cyc + 1;

   always @(posedge CLOCK) begin
      apa  <= addr_a;
      apb0 <= addr_b;
      apb1 <= apb0;
      apb2 <= apb1;
   end

   assign rdata_a = 32'(apa) + 32'd100;
   assign rdata_b = 32'(apb2) + 32'd100;

   weight_loader #(
      .DATA_W(32), .NUM_UNITS(4), .WEIGHTS_PER_UNIT(8),
      .ADDR_W(10), .RAM_LATENCY(1)
   ) dut_a (
      .CLOCK(CLOCK), .RESET(RESET), .start(start), .bcast(bcast),
      .base_addr(base_addr), .busy(busy_a), .done(done_a),
      .ram_rd(rd_a), .ram_addr(addr_a), .ram_out(rdata_a),
      .weight(weight_a), .write(write_a)
   );

   weight_loader #(
      .DATA_W(32), .NUM_UNITS(4), .WEIGHTS_PER_UNIT(8),
      .ADDR_W(10), .RAM_LATENCY(3)
   ) dut_b (
      .CLOCK(CLOCK), .RESET(RESET), .start(start), .bcast(bcast),
      .base_addr(base_addr), .busy(busy_b), .done(done_b),
      .ram_rd(rd_b), .ram_addr(addr_b), .ram_out(rdata_b),
      .weight(weight_b), .write(write_b)
   );

   task automatic chki(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
      end
   endtask

   task automatic chkv(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic chk_idle();
      chki("idle_a_ctl", int'({busy_a, done_a, rd_a, write_a}), 0);
      chki("idle_a_addr", int'(addr_a), 0);
      chkv("idle_a_wt", weight_a, '0);
      chki("idle_b_ctl", int'({busy_b, done_b, rd_b, write_b}), 0);
      chki("idle_b_addr", int'(addr_b), 0);
      chkv("idle_b_wt", weight_b, '0);
   endtask

   // expectations relative to c0, the cycle in which start is sampled
   task automatic push_run(input int c0, input logic [9:0] base,
                           input logic bc, input int cut);
      int           n;
      logic [9:0]   a;
      logic [31:0]  d;
      logic [3:0]   m;
      logic [127:0] wt;
      n = bc ? 8 : 32;
      for (int k = 0; k < n; k++) begin
         a = base + 10'(k);
         d = 32'(a) + 32'd100;
         m = bc ? 4'hF : 4'(1 << (k / 8));
         for (int u = 0; u < 4; u++)
            wt[u*32 +: 32] = m[u] ? d : 32'd0;
         if (1 + k <= cut) rqa.push_back('{c0 + 1 + k, a});
         if (3 + k <= cut) wqa.push_back('{c0 + 3 + k, m, wt});
         if (5 + k <= cut) wqb.push_back('{c0 + 5 + k, m, wt});
      end
      if (n + 3 <= cut) dqa.push_back(c0 + n + 3);
      if (n + 5 <= cut) dqb.push_back(c0 + n + 5);
      ba_lo = c0 + 1;
      ba_hi = c0 + ((n + 2 < cut) ? n + 2 : cut);
      bb_lo = c0 + 1;
      bb_hi = c0 + ((n + 4 < cut) ? n + 4 : cut);
   endtask

   task automatic run(input logic [9:0] base, input logic bc,
                      input int cut, input int pulse2);
      int c0;
      c0 = cyc;
      push_run(c0, base, bc, cut);
      bcast     = bc;
      base_addr = base;
      start     = 1'b1;
      for (int i = 0; i < 46; i++) begin
         @(negedge CLOCK);
         start = (cyc == c0 + pulse2);
         RESET = (cyc == c0 + cut);
         if (cyc == c0 + cut + 1)
            chk_idle();
      end
      start = 1'b0;
      RESET = 1'b0;
   endtask

   always @(negedge CLOCK) begin
      rexp_t ra;
      wexp_t wa;
      wexp_t wb;
      if (mon_on) begin
         chki("busy_a", int'(busy_a), int'(cyc >= ba_lo && cyc <= ba_hi));
         chki("busy_b", int'(busy_b), int'(cyc >= bb_lo && cyc <= bb_hi));
         if (rd_a) begin
            if (rqa.size() == 0) chki("rd_a_extra", int'(rd_a), 0);
            else begin
               ra = rqa.pop_front();
               chki("rd_a_cyc", cyc, ra.cyc);
               chki("rd_a_addr", int'(addr_a), int'(ra.addr));
            end
         end
         if (write_a != 0) begin
            if (wqa.size() == 0) chki("wr_a_extra", int'(write_a), 0);
            else begin
               wa = wqa.pop_front();
               chki("wr_a_cyc", cyc, wa.cyc);
               chki("wr_a_mask", int'(write_a), int'(wa.wr));
               chkv("wr_a_data", weight_a, wa.wt);
            end
         end else begin
            chkv("wt_a_zero", weight_a, '0);
         end
         if (write_b != 0) begin
            if (wqb.size() == 0) chki("wr_b_extra", int'(write_b), 0);
            else begin
               wb = wqb.pop_front();
               chki("wr_b_cyc", cyc, wb.cyc);
               chki("wr_b_mask", int'(write_b), int'(wb.wr));
               chkv("wr_b_data", weight_b, wb.wt);
            end
         end else begin
            chkv("wt_b_zero", weight_b, '0);
         end
         if (done_a) begin
            if (dqa.size() == 0) chki("done_a_extra", int'(done_a), 0);
            else chki("done_a_cyc", cyc, dqa.pop_front());
         end
         if (done_b) begin
            if (dqb.size() == 0) chki("done_b_extra", int'(done_b), 0);
            else chki("done_b_cyc", cyc, dqb.pop_front());
         end
      end
   end

   initial begin
      RESET     = 1'b1;
      start     = 1'b0;
      bcast     = 1'b0;
      base_addr = '0;
      repeat (3) @(negedge CLOCK);
      chk_idle();
      RESET  = 1'b0;
      mon_on = 1;
      run(10'd16,   1'b0, 1000, -1);
      run(10'd0,    1'b1, 1000, -1);
      run(10'd1020, 1'b0, 1000, -1);
      run(10'd0,    1'b0, 1000, 10);
      run(10'd5,    1'b0, 12,   -1);
      run(10'd40,   1'b0, 1000, -1);
      @(negedge CLOCK);
      chki("left_rd_a", rqa.size(), 0);
      chki("left_wr_a", wqa.size(), 0);
      chki("left_wr_b", wqb.size(), 0);
      chki("left_done_a", dqa.size(), 0);
      chki("left_done_b", dqb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
- Parametrised successor to the fixed four-way weight RAM demultiplexer.
- Autonomously sequences reads from the weight RAM and distributes each returned word to one of NUM_UNITS neuron units, or to all units at once.
- Sits between the weight RAM and the neuron array.
- Supports configurable RAM read latency, a start/busy/done handshake and a broadcast mode.

Parameters:
- DATA_W, 32: weight word width.
- NUM_UNITS, 4: number of destination neuron units (>=1).
- WEIGHTS_PER_UNIT, 8: words loaded per unit per run (>=1).
- ADDR_W, 10: RAM address width.
- RAM_LATENCY, 1: cycles from ram_rd asserted to ram_out valid (>=1).

Ports:
- CLOCK  input  1  system clock, all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  begin a load run; sampled only in IDLE.
- bcast  input  1  broadcast mode; captured with start.
- base_addr  input  ADDR_W  first RAM address; captured with start.
- busy  output  1  run in progress.
- done  output  1  one-cycle pulse at end of run.
- ram_rd  output  1  RAM read strobe.
- ram_addr  output  ADDR_W  RAM read address.
- ram_out  input  DATA_W  RAM read data.
- weight  output  NUM_UNITS*DATA_W  flattened; unit u occupies bits [u*DATA_W +: DATA_W].
- write  output  NUM_UNITS  per-unit write strobe; bit u belongs to unit u.

Behaviour:
- Reset (RESET high at an edge):
  - All outputs cleared: busy=0, done=0, ram_rd=0, ram_addr=0, weight=0, write=0.
  - FSM goes to IDLE, counters cleared, latency pipeline flushed.
  - Reset mid-run aborts the run immediately; no done pulse; returned data still in flight is discarded.
- Run length:
  - N = NUM_UNITS*WEIGHTS_PER_UNIT words when bcast=0.
  - N = WEIGHTS_PER_UNIT words when bcast=1.
- FSM states: IDLE, ISSUE, DRAIN, FINISH.
  - IDLE: start=1 at an edge captures base_addr and bcast, clears the issue counter k, and moves to ISSUE. start is ignored in every other state.
  - ISSUE: each cycle drives ram_rd=1 and ram_addr=(base_addr+k) mod 2^ADDR_W, then increments k. After issuing k=N-1, moves to DRAIN.
  - DRAIN: ram_rd=0. Waits until the last returned word has been written to the outputs, then moves to FINISH.
  - FINISH: done=1 for exactly one cycle, then IDLE.
- Unit selection:
  - bcast=0: unit index u=k/WEIGHTS_PER_UNIT, so unit 0 receives the first WEIGHTS_PER_UNIT words, unit 1 the next block, and so on.
  - bcast=1: every unit is selected for every word.
  - u, plus a valid bit, travels through a RAM_LATENCY-deep shift register alongside the read.
- Output register:
  - When the pipelined valid bit emerges, at that edge: slice u of weight <= ram_out and write[u] <= 1. All other slices and bits <= 0.
  - bcast=1: all slices <= ram_out and write <= all ones.
  - When no valid emerges: weight <= 0 and write <= 0. Outputs are registered and never hold stale data.
- Latency:
  - ram_rd high in cycle t; ram_out sampled in cycle t+RAM_LATENCY; weight/write visible in cycle t+RAM_LATENCY+1.
  - Start sampled in cycle 0 → reads in cycles 1..N → writes in cycles 2+RAM_LATENCY .. N+1+RAM_LATENCY → done in cycle N+2+RAM_LATENCY.
- busy:
  - 1 from the first ISSUE cycle through the last write cycle inclusive.
  - 0 in the done cycle and in IDLE.
- Boundaries:
  - Address wraps modulo 2^ADDR_W with no error.
  - start held high through a run is ignored until IDLE is reached. If still high in IDLE, a new run starts in the cycle after done.
  - Exactly one write bit is high per cycle in non-broadcast mode.
  - With NUM_UNITS=1 and WEIGHTS_PER_UNIT=1, N=1 and the sequence above still holds.

Test Plan:
- Defaults, RAM[a]=a+100, start with base_addr=16, bcast=0 at cycle 0:
  - ram_rd high cycles 1..32 with addr 16..47.
  - write[0] high cycles 3..10 carrying values 116..123, write[1] cycles 11..18, up to write[3] cycles 27..34.
  - Non-selected slices read 0; done high cycle 35 only; busy high cycles 1..34.
- bcast=1, base_addr=0:
  - 8 reads in cycles 1..8.
  - write=4'b1111 cycles 3..10 with all four slices equal to RAM[k].
  - done cycle 11.
- RAM_LATENCY=3, defaults otherwise, base 0:
  - First write cycle 5, last write cycle 36, done cycle 37.
  - Data order is unchanged.
- base_addr=1020, ADDR_W=10:
  - ram_addr sequence 1020,1021,1022,1023,0,1,… with no gap.
  - Unit 0 receives RAM[1020..1023] then RAM[0..3].
- start pulsed again at cycle 10 mid-run:
  - Ignored; exactly 32 writes and one done pulse.
- RESET asserted at cycle 12 of a run:
  - Cycle 13 shows all outputs 0 and the FSM in IDLE; no further writes; no done.
  - A new start afterwards completes normally.
